// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared LFSR state encodings and standard PRBS tap masks
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Bit i set means stage i+1 feeds the XOR.
    localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;
    localparam logic [22:0] PRBS23_TAPS = 23'h42_0000;
    localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;

    function automatic logic [31:0] prbs_taps(input int unsigned width);
        logic [31:0] t;
        case (width)
            7:       t = 32'(PRBS7_TAPS);
            15:      t = 32'(PRBS15_TAPS);
            23:      t = 32'(PRBS23_TAPS);
            31:      t = 32'(PRBS31_TAPS);
            default: t = (32'd1 << (width - 1)) | (32'd1 << (width - 2));
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - bit stream and status bundle of the checker; LFSR_CHK_STICKY_EN adds errSticky
interface lfsr_checker_if #(
    parameter int unsigned ERR_W = 16
);
    logic             ckEn;
    logic             dataIn;
    logic             errCntClr;
    logic             locked;
    logic             errPulse;
    logic             syncLoss;
    logic [ERR_W-1:0] errCnt;

`ifdef LFSR_CHK_STICKY_EN
    logic             errSticky;

    modport master (
        output ckEn, dataIn, errCntClr,
        input  locked, errPulse, syncLoss, errCnt, errSticky
    );
    modport slave (
        input  ckEn, dataIn, errCntClr,
        output locked, errPulse, syncLoss, errCnt, errSticky
    );
`else
    modport master (
        output ckEn, dataIn, errCntClr,
        input  locked, errPulse, syncLoss, errCnt
    );
    modport slave (
        input  ckEn, dataIn, errCntClr,
        output locked, errPulse, syncLoss, errCnt
    );
`endif

endinterface

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - next LFSR bit as XOR of the tapped stages, common to generator and checker
module lfsr_step #(
    parameter int unsigned     WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(7'h60)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic             bit_o
);

    assign bit_o = ^(state_i & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with error count and sync-loss detection
// Optional errSticky output is built when LFSR_CHK_STICKY_EN is defined.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int unsigned      WIDTH    = 7,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(prbs_taps(WIDTH)),
    parameter int unsigned      LOCK_CNT = 16,
    parameter int unsigned      LOSS_WIN = 64,
    parameter int unsigned      LOSS_THR = 8,
    parameter int unsigned      ERR_W    = 16
) (
    input  logic          ckIn,
    input  logic          rstN,
    lfsr_checker_if.slave bus
);

    localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int unsigned WERR_W  = $clog2(LOSS_THR + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_THR   = WERR_W'(LOSS_THR);

    chk_state_e         state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic [WERR_W-1:0]  werr_inc;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               sync_loss_q, sync_loss_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pred_bit;
    logic               bit_err;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i (sr_q),
        .bit_o   (pred_bit)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        werr_inc    = werr_q;
        err_pulse_d = 1'b0;
        sync_loss_d = 1'b0;
        bit_err     = 1'b0;

        if (bus.ckEn) begin
            case (state_q)
                ST_SEEK: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.dataIn};
                    // An all-zero register is the LFSR lockup state; keep filling until a 1 arrives.
                    if (fill_q >= FILL_LAST) begin
                        fill_d = FILL_FULL;
                        if (sr_d != '0) begin
                            state_d = ST_VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.dataIn};
                    if (bus.dataIn == pred_bit) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_LOCK) begin
                            state_d = ST_LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        fill_d  = '0;
                        state_d = ST_SEEK;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the local LFSR runs on its own prediction so line errors cannot corrupt it.
                    sr_d        = {sr_q[WIDTH-2:0], pred_bit};
                    bit_err     = bus.dataIn ^ pred_bit;
                    err_pulse_d = bit_err;
                    werr_inc    = werr_q + WERR_W'(bit_err);
                    if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_inc;
                    end
                    if (werr_inc == WERR_THR) begin
                        state_d     = ST_SEEK;
                        sync_loss_d = 1'b1;
                        fill_d      = '0;
                        match_d     = '0;
                        win_d       = '0;
                        werr_d      = '0;
                    end
                end
                default: begin
                    state_d = ST_SEEK;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end

        // Clear beats a same-edge error: that error is dropped from the count.
        if (bus.errCntClr) begin
            err_cnt_d = '0;
        end else if (bit_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge ckIn or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_SEEK;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_loss_q <= sync_loss_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.locked   = locked_q;
    assign bus.errPulse = err_pulse_q;
    assign bus.syncLoss = sync_loss_q;
    assign bus.errCnt   = err_cnt_q;

`ifdef LFSR_CHK_STICKY_EN
    logic sticky_q;
    logic sticky_d;

    assign sticky_d = bus.errCntClr ? 1'b0 : (sticky_q | bit_err);

    always_ff @(posedge ckIn or negedge rstN) begin
        if (!rstN) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.errSticky = sticky_q;
`endif

endmodule
